// File: rtl/sound_frame_seq_pkg.sv
// Shared sound constants: frame sequencer step masks and default prescale.
// Bit i of each mask selects the strobe fired on sequencer step i.
package sound_frame_seq_pkg;

  localparam int FS_STEPS = 8;

  localparam logic [7:0] FS_LEN_MASK = 8'b0101_0101;
  localparam logic [7:0] FS_SWP_MASK = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_MASK = 8'b1000_0000;

  // 4.194304 MHz / 8192 = 512 Hz sequencer rate
  localparam int FS_PRESCALE_DEF = 8192;

endpackage

// File: rtl/sound_prescaler.sv
// Modulo-PRESCALE counter with enable and synchronous clear.
// Ports: clk, rst_n, en, clr in; tc out (high on the wrap cycle while enabled).
module sound_prescaler #(
  parameter int PRESCALE = 8192
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  assign tc = en & (pre == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      if (tc) pre <= '0;
      else    pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 8-step walk producing length/sweep/envelope strobes.
// Ports: clk, rst_n, apu_on, ext_tick in; clk_length_ctr, clk_sweep,
// clk_envelope, frame_step[2:0], length_next out.
module sound_frame_seq
  import sound_frame_seq_pkg::*;
#(
  parameter int PRESCALE     = FS_PRESCALE_DEF,
  parameter bit USE_EXT_TICK = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_on,
  input  logic       ext_tick,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_envelope,
  output logic [2:0] frame_step,
  output logic       length_next
);

  logic       step_ev;
  logic [2:0] step;

  generate
    if (USE_EXT_TICK) begin : g_ext
      assign step_ev = apu_on & ext_tick;
    end else begin : g_int
      logic tc;
      logic unused_ext;
      assign unused_ext = ext_tick;

      // Cleared while powered off so power-on starts a full period
      sound_prescaler #(
        .PRESCALE(PRESCALE)
      ) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (apu_on),
        .clr  (~apu_on),
        .tc   (tc)
      );

      assign step_ev = tc;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step           <= 3'd0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_envelope   <= 1'b0;
    end else if (!apu_on) begin
      step           <= 3'd0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_envelope   <= 1'b0;
    end else begin
      clk_length_ctr <= step_ev & FS_LEN_MASK[step];
      clk_sweep      <= step_ev & FS_SWP_MASK[step];
      clk_envelope   <= step_ev & FS_ENV_MASK[step];
      if (step_ev) step <= step + 3'd1;
    end
  end

  assign frame_step  = step;
  assign length_next = ~step[0];

endmodule
